alarma_multi: RTL
=================

Name: alarma_multi

Overview:
- Multi-channel successor to the single-bit alarm blinker.
- Each channel watches one timer-finished flag and drives a blink flag for the display.
- Blink rate is programmable, and the user can acknowledge (silence) a ringing channel.
- Sits between the chronometer/timer counters and the display/segment driver, in the CLK_Ring domain.

Parameters:
- NUM_CH, 3, number of independent alarm channels.
- HALF_PERIOD, 1, CLK_Ring cycles between blink toggles. Must be >= 1; 1 means toggle every cycle.
- DIV_W, 8, width of the blink divider counter. Requires HALF_PERIOD <= 2^DIV_W.
- MAX_TOGGLES, 60, toggles before auto-off (used only with ALARMA_AUTO_OFF_EN).
- TOG_W, 8, width of the toggle counter. Requires MAX_TOGGLES < 2^TOG_W.

Ports:
- CLK_Ring  input  1  ring/blink clock; all state is on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- fin_crono  input  NUM_CH  per-channel timer-finished level.
- enable  input  NUM_CH  per-channel arm mask; 0 forces the channel idle.
- ack  input  NUM_CH  per-channel acknowledge/silence level, sampled each edge.
- band_parp  output  NUM_CH  per-channel blink flag to the display.
- ringing  output  NUM_CH  1 while the channel is in RING.
- timed_out  output  NUM_CH  sticky auto-off indicator. Tied 0 without the macro.
- alarm_any  output  1  OR of ringing.

Behaviour:
- Reset (reset=0, asynchronous):
  - all channels go to IDLE; divider and toggle counters go to 0.
  - band_parp, ringing, timed_out and alarm_any are all 0 immediately, without waiting for a clock edge.
  - Reset mid-RING aborts the blink with no residual state.
- Per-channel FSM, 2-bit state:
  - IDLE: band_parp=0.
  - RING: blinking.
  - SILENCED: band_parp=0; waits for fin_crono to drop.
- Transition priority per edge, highest first:
  1. fin_crono=0 or enable=0 -> IDLE; clears band_parp, counters and timed_out.
  2. ack=1 -> SILENCED.
  3. auto-off (macro only).
  4. blink divider.
- IDLE -> RING on fin_crono=1, enable=1, ack=0.
  - On that same edge band_parp<=1, div<=0, tog<=1.
  - So band_parp is high one cycle after fin_crono is sampled high, as in the previous generation.
- IDLE with fin_crono=1 and ack=1 -> SILENCED directly; no blink.
- RING, each edge:
  - if div==HALF_PERIOD-1: band_parp<=~band_parp, div<=0, tog<=tog+1 (saturating at 2^TOG_W-1).
  - else div<=div+1.
  - With HALF_PERIOD=1 the output toggles every cycle.
- RING -> SILENCED on ack=1: band_parp<=0 on the same edge.
- SILENCED -> IDLE only when fin_crono=0 (or enable=0). Holding ack, or releasing it, keeps the channel in SILENCED.
- A new fin_crono rising after IDLE re-arms ringing normally.
- Channels are fully independent; simultaneous events on different channels are processed in parallel.
- ringing[i] = (state==RING), registered.
- alarm_any is the combinational OR of the registered ringing bits, so it has zero added latency.

Optional Feature:
- Macro ALARMA_AUTO_OFF_EN.
- Defined:
  - when a toggle makes tog reach MAX_TOGGLES, the channel goes to SILENCED on that edge;
  - band_parp<=0 and timed_out[i]<=1;
  - timed_out stays 1 until the channel returns to IDLE.
- Undefined:
  - the channel rings indefinitely while fin_crono=1;
  - timed_out is constant 0;
  - the toggle counter may be omitted.

Decomposition:
- Shared package/include alarma_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RING=2'd1, ST_SIL=2'd2;
  - default HALF_PERIOD and MAX_TOGGLES constants.
- One sub-module, alarma_canal: a single channel FSM with its divider and toggle counter.
- alarma_multi instantiates NUM_CH copies in a generate loop and ORs the ringing bits.

Test Plan:
- HALF_PERIOD=1, ch0: fin_crono=1 for 6 cycles, then 0.
  - band_parp[0] = 1,0,1,0,1,0; 0 from the edge after fin_crono drops; ringing[0]=1 for those 6 cycles.
- HALF_PERIOD=4: fin_crono=1 for 20 cycles.
  - band_parp goes 1 on the first edge, then toggles every 4 cycles.
- Ringing ch1, ack[1]=1 for 1 cycle with fin_crono still 1.
  - band_parp[1]=0 and ringing[1]=0 from the next edge and stay 0 until fin_crono drops.
  - A fresh fin_crono rise rings again.
- enable[2]=0 with fin_crono[2]=1: no ring.
  - Raising enable[2] mid-stream starts RING on the next edge.
- reset pulled low mid-RING between clock edges.
  - All outputs 0 immediately.
  - After release with fin_crono still 1, ringing restarts with band_parp=1 on the first edge.
- ALARMA_AUTO_OFF_EN, MAX_TOGGLES=5, HALF_PERIOD=1:
  - after 5 toggles band_parp=0, timed_out=1, ringing=0;
  - timed_out clears when fin_crono returns to 0.
  - Without the macro, the bench checks timed_out stays 0 over 100 cycles of ringing.

Source files
------------

// File: rtl/alarma_pkg.sv
// ---------------------------------------------------------------------------
// alarma_pkg
// Shared constants for the multi-channel alarm blinker.
//   - Per-channel FSM state encodings (2-bit).
//   - Default blink half-period and auto-off toggle count.
// Optional feature macro used by the design: ALARMA_AUTO_OFF_EN.
// ---------------------------------------------------------------------------
package alarma_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RING = 2'd1;
    localparam logic [1:0] ST_SIL  = 2'd2;

    localparam int DEF_HALF_PERIOD = 1;
    localparam int DEF_MAX_TOGGLES = 60;

endpackage : alarma_pkg

// File: rtl/alarma_canal.sv
// ---------------------------------------------------------------------------
// alarma_canal
// One alarm channel: IDLE / RING / SILENCED FSM with its blink divider and
// toggle counter.
// Optional feature: `define ALARMA_AUTO_OFF_EN to silence the channel
// automatically after MAX_TOGGLES toggles and flag it on o_timed_out.
//
// Ports:
//   i_clk        ring/blink clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_fin        timer-finished level
//   i_en         arm enable; 0 forces IDLE
//   i_ack        acknowledge/silence level
//   o_band       blink flag to display
//   o_ring       1 while in RING (registered)
//   o_timed_out  sticky auto-off flag (0 when feature is disabled)
// ---------------------------------------------------------------------------
module alarma_canal
    import alarma_pkg::*;
#(
    parameter int HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int DIV_W       = 8,
    parameter int MAX_TOGGLES = DEF_MAX_TOGGLES,
    parameter int TOG_W       = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_fin,
    input  logic i_en,
    input  logic i_ack,
    output logic o_band,
    output logic o_ring,
    output logic o_timed_out
);

`ifdef ALARMA_AUTO_OFF_EN
    localparam bit AUTO_OFF = 1'b1;
`else
    localparam bit AUTO_OFF = 1'b0;
`endif

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
    localparam logic [TOG_W-1:0] TOG_MAX  = TOG_W'(MAX_TOGGLES);

    logic [1:0]       r_state;
    logic             r_band;
    logic             r_ring;
    logic             r_timed_out;
    logic [DIV_W-1:0] r_div;
    logic [TOG_W-1:0] r_tog;

    logic [TOG_W-1:0] w_tog_inc;

    // Toggle count saturates rather than wrapping so a long ring never
    // re-triggers auto-off or looks like a fresh start.
    assign w_tog_inc = (r_tog == {TOG_W{1'b1}}) ? r_tog : r_tog + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_band      <= 1'b0;
            r_ring      <= 1'b0;
            r_timed_out <= 1'b0;
            r_div       <= '0;
            r_tog       <= '0;
        end else if (!i_fin || !i_en) begin
            // Dropping the source or disarming wipes everything, including
            // a pending timed_out, so the next ring starts clean.
            r_state     <= ST_IDLE;
            r_band      <= 1'b0;
            r_ring      <= 1'b0;
            r_timed_out <= 1'b0;
            r_div       <= '0;
            r_tog       <= '0;
        end else if (i_ack) begin
            r_state <= ST_SIL;
            r_band  <= 1'b0;
            r_ring  <= 1'b0;
            r_div   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Band rises on the same edge that first sees fin high.
                    r_state <= ST_RING;
                    r_ring  <= 1'b1;
                    r_band  <= 1'b1;
                    r_div   <= '0;
                    r_tog   <= TOG_W'(1);
                end
                ST_RING: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        r_tog <= w_tog_inc;
                        if (AUTO_OFF && (w_tog_inc == TOG_MAX)) begin
                            r_state     <= ST_SIL;
                            r_ring      <= 1'b0;
                            r_band      <= 1'b0;
                            r_timed_out <= 1'b1;
                        end else begin
                            r_band <= ~r_band;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_SIL: begin
                    // Held here until fin drops; releasing ack does not re-ring.
                    r_state <= ST_SIL;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_band  <= 1'b0;
                    r_ring  <= 1'b0;
                end
            endcase
        end
    end

    assign o_band      = r_band;
    assign o_ring      = r_ring;
    assign o_timed_out = AUTO_OFF ? r_timed_out : 1'b0;

endmodule : alarma_canal

// File: rtl/alarma_multi.sv
// ---------------------------------------------------------------------------
// alarma_multi
// Multi-channel alarm blinker: NUM_CH independent alarma_canal instances
// plus a combined "any channel ringing" flag.
// Optional feature: `define ALARMA_AUTO_OFF_EN enables per-channel auto-off
// after MAX_TOGGLES blink toggles (reported on timed_out).
//
// Ports:
//   CLK_Ring   ring/blink clock, rising edge
//   reset      asynchronous active-low reset
//   fin_crono  per-channel timer-finished level
//   enable     per-channel arm mask
//   ack        per-channel acknowledge/silence
//   band_parp  per-channel blink flag
//   ringing    per-channel RING indicator (registered)
//   timed_out  per-channel sticky auto-off flag
//   alarm_any  OR of ringing
// ---------------------------------------------------------------------------
module alarma_multi
    import alarma_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int DIV_W       = 8,
    parameter int MAX_TOGGLES = DEF_MAX_TOGGLES,
    parameter int TOG_W       = 8
) (
    input  logic              CLK_Ring,
    input  logic              reset,
    input  logic [NUM_CH-1:0] fin_crono,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] band_parp,
    output logic [NUM_CH-1:0] ringing,
    output logic [NUM_CH-1:0] timed_out,
    output logic              alarm_any
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            alarma_canal #(
                .HALF_PERIOD (HALF_PERIOD),
                .DIV_W       (DIV_W),
                .MAX_TOGGLES (MAX_TOGGLES),
                .TOG_W       (TOG_W)
            ) u_canal (
                .i_clk       (CLK_Ring),
                .i_rst_n     (reset),
                .i_fin       (fin_crono[gi]),
                .i_en        (enable[gi]),
                .i_ack       (ack[gi]),
                .o_band      (band_parp[gi]),
                .o_ring      (ringing[gi]),
                .o_timed_out (timed_out[gi])
            );
        end
    endgenerate

    // Pure OR of registered bits: no extra cycle of latency.
    assign alarm_any = |ringing;

endmodule : alarma_multi
